// File: rtl/ej1_pkg.sv
// Shared definitions for the ej1 serial link: FSM states, default
// symbol geometry, idle line level and the parity helper used by both
// the transmitter and the receiver's checker.
package ej1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } ej1_state_e;

    localparam int unsigned SYM_W_DEF      = 2;
    localparam int unsigned SYM_W_MAX      = 8;
    localparam logic        IDLE_LEVEL_DEF = 1'b1;

    // Even-parity bit over a symbol zero-extended to SYM_W_MAX bits;
    // zero extension leaves the XOR unchanged.
    function automatic logic even_parity(input logic [SYM_W_MAX-1:0] sym);
        return ^sym;
    endfunction

endpackage

// File: rtl/ej1_bit_timer.sv
// Slot timer: counts CLKS_PER_BIT clocks per serial slot.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   reload     : restart the slot (asserted on every FSM state change)
//   tick       : high during the last clock of the current slot
// With CLKS_PER_BIT=1 the counter never leaves zero, so tick is constant 1.
module ej1_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

    // Slot counter: wraps at the end of each slot, restarts on reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ej1_symbol_tx.sv
// Symbol transmitter: accepts a SYM_W-bit symbol over valid/ready and
// sends it as a frame START, SYM_W DATA slots (MSB first), PARITY on
// the I line, with S marking the start slot.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   sym_in     : symbol to send, bit SYM_W-1 goes out first
//   in_valid   : sym_in is valid
//   in_ready   : combinational; a transfer can happen on this edge
//   I          : serial data line (registered)
//   S          : frame start strobe (registered)
//   busy       : frame in progress (registered)
module ej1_symbol_tx
    import ej1_pkg::*;
#(
    parameter int unsigned SYM_W        = SYM_W_DEF,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter logic        IDLE_LEVEL   = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             I,
    output logic             S,
    output logic             busy
);

    localparam int unsigned BW = $clog2(SYM_W + 1);

    ej1_state_e       state, state_d;
    logic [SYM_W-1:0] shreg, shreg_d;
    logic             par, par_d;
    logic [BW-1:0]    bit_idx, bit_d;
    logic             armed;
    logic             tick;
    logic             reload;
    logic             xfer;
    logic             i_d, s_d, busy_d;

    ej1_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .reload(reload),
        .tick  (tick)
    );

    assign reload = (state_d != state);

    // armed delays in_ready until the first edge after reset release.
    assign in_ready = rst_n & armed &
                      ((state == IDLE) | ((state == PARITY) & tick));
    assign xfer     = in_valid & in_ready;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            par     <= 1'b0;
            bit_idx <= '0;
            armed   <= 1'b0;
            I       <= IDLE_LEVEL;
            S       <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            par     <= par_d;
            bit_idx <= bit_d;
            armed   <= 1'b1;
            I       <= i_d;
            S       <= s_d;
            busy    <= busy_d;
        end
    end

    // Next state, capture and shift.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        par_d   = par;
        bit_d   = bit_idx;
        if (xfer) begin
            shreg_d = sym_in;
            par_d   = even_parity(SYM_W_MAX'(sym_in));
        end
        case (state)
            IDLE: begin
                if (xfer) state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg << 1;
                    if (bit_idx == BW'(SYM_W - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_idx + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = xfer ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the cycle after this edge, decoded from next state.
    always_comb begin
        i_d    = IDLE_LEVEL;
        s_d    = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            START: begin
                i_d    = 1'b1;
                s_d    = 1'b1;
                busy_d = 1'b1;
            end
            DATA: begin
                i_d    = shreg_d[SYM_W-1];
                busy_d = 1'b1;
            end
            PARITY: begin
                i_d    = par_d;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ej1_symbol_tx.sv
// Directed bench for ej1_symbol_tx: one instance with CLKS_PER_BIT=1 and
// one with CLKS_PER_BIT=3, sharing clock and reset.
module tb_ej1_symbol_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [1:0] sym1 = 2'b00;
    logic       val1 = 1'b0;
    logic       rdy1, i1, s1, busy1;

    logic [1:0] sym3 = 2'b00;
    logic       val3 = 1'b0;
    logic       rdy3, i3, s3, busy3;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ej1_symbol_tx #(.SYM_W(2), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sym_in(sym1), .in_valid(val1),
        .in_ready(rdy1), .I(i1), .S(s1), .busy(busy1)
    );

    ej1_symbol_tx #(.SYM_W(2), .CLKS_PER_BIT(3), .IDLE_LEVEL(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .sym_in(sym3), .in_valid(val3),
        .in_ready(rdy3), .I(i3), .S(s3), .busy(busy3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        val1  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({s1, i1, busy1, rdy1} !== 4'b0100) begin
                failed++;
                $display("FAIL reset_hold c=%0d {S,I,busy,rdy} got %b want 0100", c, {s1, i1, busy1, rdy1});
            end
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (rdy1 !== 1'b0) begin
            failed++;
            $display("FAIL reset_release_pre_edge in_ready got %b want 0", rdy1);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({s1, i1, busy1, rdy1} !== 4'b0101) begin
                failed++;
                $display("FAIL idle c=%0d {S,I,busy,rdy} got %b want 0101", c, {s1, i1, busy1, rdy1});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [1:0] exp_si [4];
        exp_si = '{2'b11, 2'b01, 2'b00, 2'b01};
        sym1 = 2'b10;
        val1 = 1'b1;
        tests++;
        if (rdy1 !== 1'b1) begin
            failed++;
            $display("FAIL single_ready got %b want 1", rdy1);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            val1 = 1'b0;
            tests++;
            if ({s1, i1, busy1} !== {exp_si[c], 1'b1}) begin
                failed++;
                $display("FAIL single c=%0d {S,I,busy} got %b want %b", c, {s1, i1, busy1}, {exp_si[c], 1'b1});
            end
        end
        step();
        tests++;
        if ({s1, i1, busy1, rdy1} !== 4'b0101) begin
            failed++;
            $display("FAIL single_idle {S,I,busy,rdy} got %b want 0101", {s1, i1, busy1, rdy1});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_sir [8];
        exp_sir = '{3'b110, 3'b010, 3'b010, 3'b001,
                    3'b110, 3'b000, 3'b000, 3'b001};
        sym1 = 2'b11;
        val1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            tests++;
            if ({s1, i1, rdy1, busy1} !== {exp_sir[c], 1'b1}) begin
                failed++;
                $display("FAIL b2b c=%0d {S,I,rdy,busy} got %b want %b", c, {s1, i1, rdy1, busy1}, {exp_sir[c], 1'b1});
            end
            if (c == 0) sym1 = 2'b00;
            if (c == 4) val1 = 1'b0;
        end
        step();
        tests++;
        if ({s1, i1, busy1} !== 3'b010) begin
            failed++;
            $display("FAIL b2b_idle {S,I,busy} got %b want 010", {s1, i1, busy1});
        end
    endtask

    task automatic test_slow_slots();
        logic [1:0] exp_si [4];
        exp_si = '{2'b11, 2'b00, 2'b01, 2'b01};
        sym3 = 2'b01;
        val3 = 1'b1;
        tests++;
        if (rdy3 !== 1'b1) begin
            failed++;
            $display("FAIL slow_ready_idle got %b want 1", rdy3);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            val3 = 1'b0;
            tests++;
            if ({s3, i3, busy3, rdy3} !== {exp_si[c/3], 1'b1, (c == 11)}) begin
                failed++;
                $display("FAIL slow c=%0d {S,I,busy,rdy} got %b want %b", c, {s3, i3, busy3, rdy3}, {exp_si[c/3], 1'b1, (c == 11)});
            end
        end
        step();
        tests++;
        if ({s3, i3, busy3} !== 3'b010) begin
            failed++;
            $display("FAIL slow_idle {S,I,busy} got %b want 010", {s3, i3, busy3});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] exp_si [4];
        exp_si = '{2'b11, 2'b00, 2'b00, 2'b00};
        sym1 = 2'b10;
        val1 = 1'b1;
        step();
        val1 = 1'b0;
        step();
        step();
        tests++;
        if ({s1, i1, busy1} !== 3'b001) begin
            failed++;
            $display("FAIL midrst_pre {S,I,busy} got %b want 001", {s1, i1, busy1});
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({s1, i1, busy1, rdy1} !== 4'b0100) begin
            failed++;
            $display("FAIL midrst_async {S,I,busy,rdy} got %b want 0100", {s1, i1, busy1, rdy1});
        end
        step();
        rst_n = 1'b1;
        step();
        sym1 = 2'b00;
        val1 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            val1 = 1'b0;
            tests++;
            if ({s1, i1, busy1} !== {exp_si[c], 1'b1}) begin
                failed++;
                $display("FAIL midrst_frame c=%0d {S,I,busy} got %b want %b", c, {s1, i1, busy1}, {exp_si[c], 1'b1});
            end
        end
        step();
        tests++;
        if ({s1, i1, busy1} !== 3'b010) begin
            failed++;
            $display("FAIL midrst_idle {S,I,busy} got %b want 010", {s1, i1, busy1});
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_sir [8];
        exp_sir = '{3'b110, 3'b010, 3'b010, 3'b001,
                    3'b110, 3'b000, 3'b010, 3'b011};
        sym1 = 2'b11;
        val1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            tests++;
            if ({s1, i1, rdy1} !== exp_sir[c]) begin
                failed++;
                $display("FAIL bp c=%0d {S,I,rdy} got %b want %b", c, {s1, i1, rdy1}, exp_sir[c]);
            end
            if (c == 0) sym1 = 2'b10;
            if (c == 1) sym1 = 2'b00;
            if (c == 2) sym1 = 2'b01;
            if (c == 4) begin
                val1 = 1'b0;
                sym1 = 2'b11;
            end
        end
        step();
        tests++;
        if ({s1, i1, busy1} !== 3'b010) begin
            failed++;
            $display("FAIL bp_idle {S,I,busy} got %b want 010", {s1, i1, busy1});
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_slow_slots();
        test_reset_mid_frame();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
